fp_add_unit: RTL
================

Name: fp_add_unit

Overview:
- Multi-cycle IEEE-754 single-precision adder/subtractor.
- Sits directly downstream of the COP1 decode. Consumes the decoded fp_add/fp_write strobes and the FP register-file read data.
- Produces the result, the destination register address and a one-cycle write enable for the FP register file.
- Fixed latency; start/busy/done handshake lets the pipeline stall while the operation is in flight.

Parameters:
- LATENCY, 4, number of execute cycles from accepted start to done. Informational; the RTL is fixed at 4 states.
- QNAN, 32'h7FC00000, canonical quiet NaN returned for every NaN-producing case.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; the decoder drives it as is_fp_op & fp_add.
- op_sub  input  1  1 = fs - ft (sign of ft inverted at accept); 0 = fs + ft.
- wr_req  input  1  fp_write from the decoder; captured at accept.
- fs  input  32  operand A, IEEE single.
- ft  input  32  operand B, IEEE single.
- fd_in  input  5  destination FP register index.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  sum. Held stable until the next done.
- fd_out  output  5  captured fd_in, valid with done.
- fp_wr_en  output  1  equals done & captured wr_req.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, fp_wr_en=0, result=0, fd_out=0.
  - All internal registers cleared.
  - An in-flight operation is discarded and produces no done after rst_n deasserts.
- FSM states: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE.
  - IDLE: if start=1, latch fs, ft (sign XOR op_sub), fd_in, wr_req; go to ALIGN; busy=1 from the next cycle.
  - ALIGN: unpack the operands; form 24-bit significands (hidden bit). Swap so A has the larger magnitude. Right-shift B by the exponent difference into a 27-bit field (guard, round, sticky). Shift >= 27 leaves sticky only.
  - ADD: same signs add, different signs subtract (A-B >= 0); 28-bit result.
  - NORM:
    - On carry-out, shift right 1, exp+1, OR lost bit into sticky.
    - Otherwise a single-cycle leading-zero count, left shift and exp decrement.
    - A zero magnitude gives exact zero.
  - ROUND:
    - Round-to-nearest-even on guard/round/sticky. Renormalise if rounding carries out.
    - Pack the result, register it, pulse done, return to IDLE.
- Timing: start sampled at edge N → done=1 in the cycle following edge N+4. busy is high from edge N+1 to edge N+4, and low in the done cycle.
- start is ignored while busy=1; no queueing.
- start is accepted in the done cycle, giving back-to-back ops at 1 per 5 cycles.
- Special cases, resolved in ALIGN, pass straight through to ROUND's output register with the same latency:
  - Any NaN input → QNAN.
  - +Inf + -Inf → QNAN.
  - Inf + finite → that Inf.
  - Denormal inputs are flushed to signed zero before use.
  - Exact-zero sum → +0, except (-0)+(-0) → -0.
- Overflow (biased exp >= 255 after rounding) → signed Inf.
- Underflow (biased exp <= 0) → signed zero. No denormal outputs.
- No exception flags.

Test Plan:
- 1.0+2.0: fs=3F800000, ft=40000000, op_sub=0, start at edge N → done at edge N+4 cycle, result=40400000, fp_wr_en=1 (wr_req=1), fd_out=fd_in.
- Cancellation: fs=3F800000, ft=3F800000, op_sub=1 → result=00000000; then ft=BF800000, op_sub=0 → 00000000.
- Rounding:
  - 3F800000+33800000 (exact tie) → 3F800000 (even).
  - 3F800000+33C00000 → 3F800001.
  - 7F7FFFFF+7F7FFFFF → 7F800000.
- Specials:
  - 7F800000+FF800000 → 7FC00000.
  - 7FC00001+3F800000 → 7FC00000.
  - 00000001+3F800000 → 3F800000 (denormal flushed).
- Handshake: start held high 10 cycles → exactly two dones, 5 cycles apart. A start while busy with different operands does not alter result. wr_req=0 → done=1, fp_wr_en=0.
- Reset mid-op: rst_n=0 for one cycle while in ADD → busy, done, result immediately 0. No done pulse in the following 8 cycles. A new start then completes normally.

Source files
------------

// File: rtl/fp_add_unit.sv
// fp_add_unit: multi-cycle IEEE-754 single-precision adder/subtractor with start/busy/done handshake
module fp_add_unit #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op_sub,
  input  logic        wr_req,
  input  logic [31:0] fs,
  input  logic [31:0] ft,
  input  logic [4:0]  fd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  fd_out,
  output logic        fp_wr_en
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;
  state_t state;
  logic [31:0] a_r, b_r, spec_v_r;
  logic [4:0] fd_r;
  logic wr_r, sgn_r, sub_r, zs_r, spec_r, nz_r;
  logic [26:0] fa_r, fb_r, nm_r;
  logic [7:0] exp_r;
  logic [27:0] sum_r;
  logic [9:0] ne_r;
  logic [7:0] ea, eb, el, es, diff;
  logic [22:0] ma, mb;
  logic nan_a, nan_b, inf_a, inf_b, spec_c, swap, sl, ss, lost;
  logic [31:0] spec_v;
  logic [23:0] sig_l, sig_s;
  logic [26:0] ext, sh, fb_c;
  logic [4:0] lz;
  logic [26:0] nm_c;
  logic [9:0] ne_c, re;
  logic up;
  logic [24:0] rs;
  logic [22:0] frac;
  logic [31:0] res_c;
  // Unpack, flush denormals, detect specials, order by magnitude and align the smaller operand
  always_comb begin
    ea = a_r[30:23];
    eb = b_r[30:23];
    ma = ea == 8'd0 ? 23'd0 : a_r[22:0];
    mb = eb == 8'd0 ? 23'd0 : b_r[22:0];
    nan_a = ea == 8'hff && ma != 23'd0;
    nan_b = eb == 8'hff && mb != 23'd0;
    inf_a = ea == 8'hff && ma == 23'd0;
    inf_b = eb == 8'hff && mb == 23'd0;
    spec_c = nan_a | nan_b | inf_a | inf_b;
    spec_v = (nan_a | nan_b | (inf_a & inf_b & (a_r[31] ^ b_r[31]))) ? QNAN :
             inf_a ? {a_r[31], 8'hff, 23'd0} : {b_r[31], 8'hff, 23'd0};
    swap = {eb, mb} > {ea, ma};
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    sig_l = {el != 8'd0, swap ? mb : ma};
    sig_s = {es != 8'd0, swap ? ma : mb};
    sl = swap ? b_r[31] : a_r[31];
    ss = swap ? a_r[31] : b_r[31];
    diff = el - es;
    ext = {sig_s, 3'b000};
    sh = ext >> diff;
    lost = |(ext & ((27'd1 << diff) - 27'd1));
    fb_c = diff >= 8'd27 ? {26'd0, sig_s != 24'd0} : {sh[26:1], sh[0] | lost};
  end
  // Normalise the raw sum: carry-out shifts right, otherwise leading-zero count and shift left
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) if (sum_r[i]) lz = 5'(26 - i);
    nm_c = sum_r[27] ? {sum_r[27:2], sum_r[1] | sum_r[0]} : sum_r[26:0] << lz;
    ne_c = sum_r[27] ? {2'b00, exp_r} + 10'd1 : {2'b00, exp_r} - {5'd0, lz};
  end
  // Round to nearest even, renormalise on carry, clamp to Inf or zero and pack
  always_comb begin
    up = nm_r[2] & (nm_r[1] | nm_r[0] | nm_r[3]);
    rs = {1'b0, nm_r[26:3]} + {24'd0, up};
    re = rs[24] ? ne_r + 10'd1 : ne_r;
    frac = rs[24] ? rs[23:1] : rs[22:0];
    res_c = spec_r ? spec_v_r :
            nz_r ? {zs_r, 31'd0} :
            (!re[9] && re >= 10'd255) ? {sgn_r, 8'hff, 23'd0} :
            (re[9] || re == 10'd0) ? {sgn_r, 31'd0} :
            {sgn_r, re[7:0], frac};
  end
  // Sequencer and pipeline registers; one stage per state, outputs registered in ROUND
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      fp_wr_en <= 1'b0;
      result <= 32'd0;
      fd_out <= 5'd0;
      a_r <= 32'd0;
      b_r <= 32'd0;
      fd_r <= 5'd0;
      wr_r <= 1'b0;
      fa_r <= 27'd0;
      fb_r <= 27'd0;
      exp_r <= 8'd0;
      sgn_r <= 1'b0;
      sub_r <= 1'b0;
      zs_r <= 1'b0;
      spec_r <= 1'b0;
      spec_v_r <= 32'd0;
      sum_r <= 28'd0;
      nm_r <= 27'd0;
      ne_r <= 10'd0;
      nz_r <= 1'b0;
    end else begin
      done <= 1'b0;
      fp_wr_en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_r <= fs;
          b_r <= {ft[31] ^ op_sub, ft[30:0]};
          fd_r <= fd_in;
          wr_r <= wr_req;
          busy <= 1'b1;
          state <= ALIGN;
        end
        ALIGN: begin
          fa_r <= {sig_l, 3'b000};
          fb_r <= fb_c;
          exp_r <= el;
          sgn_r <= sl;
          sub_r <= sl ^ ss;
          zs_r <= sl & ss;
          spec_r <= spec_c;
          spec_v_r <= spec_v;
          state <= ADD;
        end
        ADD: begin
          sum_r <= sub_r ? {1'b0, fa_r} - {1'b0, fb_r} : {1'b0, fa_r} + {1'b0, fb_r};
          state <= NORM;
        end
        NORM: begin
          nm_r <= nm_c;
          ne_r <= ne_c;
          nz_r <= sum_r == 28'd0;
          state <= ROUND;
        end
        ROUND: begin
          result <= res_c;
          fd_out <= fd_r;
          done <= 1'b1;
          fp_wr_en <= wr_r;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
